sim_argmax_accumulator: RTL and testbench

- Downstream of the segment-wise similarity stage; consumes one per-segment overlap count per handshake.
- Sums NB_OF_SEGMENTS counts into one hypervector-level similarity per class prototype.
- Repeats this for NB_OF_CLASSES prototypes and tracks the arg-max class.
- Presents the winning class index and its score to the classifier control through a valid/ready handshake.

---
 rtl/sim_argmax_accumulator.sv | 150 +++++++++++++++
 tb/tb_sim_argmax_accumulator.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sim_argmax_accumulator.sv
// Sums per-segment overlap counts into one similarity per class prototype and
// tracks the arg-max class over a query, handing the winner over valid/ready.
module sim_argmax_accumulator #(
  parameter int LENGTH_SEGMENT = 32,
  parameter int NB_OF_SEGMENTS = 32,
  parameter int NB_OF_CLASSES  = 16,
  parameter int CNT_W          = $clog2(LENGTH_SEGMENT + 1),
  parameter int SIM_W          = $clog2(LENGTH_SEGMENT * NB_OF_SEGMENTS + 1),
  parameter int CLASS_W        = (NB_OF_CLASSES > 1) ? $clog2(NB_OF_CLASSES) : 1
) (
  input  logic               clk,
  input  logic               arst_n_in,
  input  logic               start_query,
  input  logic [CNT_W-1:0]   seg_count,
  input  logic               seg_count_valid,
  output logic               seg_ready,
  output logic [SIM_W-1:0]   class_sim,
  output logic               class_sim_valid,
  output logic [CLASS_W-1:0] best_class,
  output logic [SIM_W-1:0]   best_sim,
  output logic               result_valid,
  input  logic               result_ready,
  output logic               busy,
  output logic               err_overflow
);

  localparam int SEG_W = (NB_OF_SEGMENTS > 1) ? $clog2(NB_OF_SEGMENTS) : 1;
  localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(LENGTH_SEGMENT);
  localparam logic [SEG_W-1:0]   SEG_LAST   = SEG_W'(NB_OF_SEGMENTS - 1);
  localparam logic [CLASS_W-1:0] CLASS_LAST = CLASS_W'(NB_OF_CLASSES - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, COMPARE, DONE} state_t;

  function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] c);
    return (c > CNT_MAX) ? CNT_MAX : c;
  endfunction

  state_t             state_q;
  logic [SIM_W-1:0]   acc_q;
  logic [SIM_W-1:0]   acc_d;
  logic [SEG_W-1:0]   seg_idx_q;
  logic [CLASS_W-1:0] class_idx_q;
  logic [CLASS_W-1:0] best_class_q;
  logic [SIM_W-1:0]   best_sim_q;
  logic [SIM_W-1:0]   class_sim_q;
  logic               class_sim_valid_q;
  logic               result_valid_q;
  logic               seg_ready_q;
  logic               busy_q;
  logic               err_q;

  logic xfer;
  logic seg_ovf;
  logic last_seg;
  logic last_class;
  logic better;

  always_comb begin
    xfer       = seg_count_valid && seg_ready_q;
    seg_ovf    = seg_count > CNT_MAX;
    acc_d      = acc_q + SIM_W'(clamp_count(seg_count));
    last_seg   = seg_idx_q == SEG_LAST;
    last_class = class_idx_q == CLASS_LAST;
    // Strict compare: on a tie the earlier (lower) class index is kept.
    better     = (class_idx_q == '0) || (acc_q > best_sim_q);
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q           <= IDLE;
      acc_q             <= '0;
      seg_idx_q         <= '0;
      class_idx_q       <= '0;
      best_class_q      <= '0;
      best_sim_q        <= '0;
      class_sim_q       <= '0;
      class_sim_valid_q <= 1'b0;
      result_valid_q    <= 1'b0;
      seg_ready_q       <= 1'b0;
      busy_q            <= 1'b0;
      err_q             <= 1'b0;
    end else begin
      class_sim_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_query) begin
            state_q      <= ACCUM;
            acc_q        <= '0;
            seg_idx_q    <= '0;
            class_idx_q  <= '0;
            best_class_q <= '0;
            best_sim_q   <= '0;
            err_q        <= 1'b0;
            seg_ready_q  <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        ACCUM: begin
          if (xfer) begin
            acc_q <= acc_d;
            if (seg_ovf) err_q <= 1'b1;
            if (last_seg) begin
              // class_sim is presented during the single COMPARE cycle
              state_q           <= COMPARE;
              seg_ready_q       <= 1'b0;
              class_sim_q       <= acc_d;
              class_sim_valid_q <= 1'b1;
            end else begin
              seg_idx_q <= seg_idx_q + 1'b1;
            end
          end
        end
        COMPARE: begin
          if (better) begin
            best_sim_q   <= acc_q;
            best_class_q <= class_idx_q;
          end
          if (last_class) begin
            state_q        <= DONE;
            result_valid_q <= 1'b1;
          end else begin
            state_q     <= ACCUM;
            class_idx_q <= class_idx_q + 1'b1;
            acc_q       <= '0;
            seg_idx_q   <= '0;
            seg_ready_q <= 1'b1;
          end
        end
        DONE: begin
          if (result_ready) begin
            state_q        <= IDLE;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign seg_ready       = seg_ready_q;
  assign class_sim       = class_sim_q;
  assign class_sim_valid = class_sim_valid_q;
  assign best_class      = best_class_q;
  assign best_sim        = best_sim_q;
  assign result_valid    = result_valid_q;
  assign busy            = busy_q;
  assign err_overflow    = err_q;

endmodule

// File: tb/tb_sim_argmax_accumulator.sv
// Scoreboard bench for sim_argmax_accumulator: 4 segments x 3 classes, directed
// count vectors with hand-computed class sums and arg-max results.
module tb_sim_argmax_accumulator;

  localparam int LS      = 32;
  localparam int NS      = 4;
  localparam int NC      = 3;
  localparam int CNT_W   = $clog2(LS + 1);
  localparam int SIM_W   = $clog2(LS * NS + 1);
  localparam int CLASS_W = $clog2(NC);

  logic               clk = 1'b0;
  logic               arst_n_in = 1'b0;
  logic               start_query = 1'b0;
  logic [CNT_W-1:0]   seg_count = '0;
  logic               seg_count_valid = 1'b0;
  logic               seg_ready;
  logic [SIM_W-1:0]   class_sim;
  logic               class_sim_valid;
  logic [CLASS_W-1:0] best_class;
  logic [SIM_W-1:0]   best_sim;
  logic               result_valid;
  logic               result_ready = 1'b0;
  logic               busy;
  logic               err_overflow;

  sim_argmax_accumulator #(
    .LENGTH_SEGMENT(LS),
    .NB_OF_SEGMENTS(NS),
    .NB_OF_CLASSES (NC)
  ) dut (
    .clk            (clk),
    .arst_n_in      (arst_n_in),
    .start_query    (start_query),
    .seg_count      (seg_count),
    .seg_count_valid(seg_count_valid),
    .seg_ready      (seg_ready),
    .class_sim      (class_sim),
    .class_sim_valid(class_sim_valid),
    .best_class     (best_class),
    .best_sim       (best_sim),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .busy           (busy),
    .err_overflow   (err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cls;
    int sim;
  } res_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_cs_q[$];
  res_t exp_res_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a class sum or a result.
  always @(negedge clk) begin
    if (arst_n_in) begin
      if (class_sim_valid) begin
        check("compare_seg_ready", {31'd0, seg_ready}, 0);
        if (exp_cs_q.size() == 0) check("unexpected_class_sim", 1, 0);
        else check("class_sim", {{(32-SIM_W){1'b0}}, class_sim}, exp_cs_q.pop_front());
      end
      if (result_valid && result_ready) begin
        if (exp_res_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          res_t r;
          r = exp_res_q.pop_front();
          check("best_class", {{(32-CLASS_W){1'b0}}, best_class}, r.cls);
          check("best_sim", {{(32-SIM_W){1'b0}}, best_sim}, r.sim);
        end
      end
    end
  end

  // Sends the first nsend counts of vec; transfer happens on the edge where valid && seg_ready.
  task automatic drive_segs(input int vec[NS*NC], input int nsend, input bit gaps);
    int  i     = 0;
    int  guard = 0;
    bit  ok;
    while (i < nsend && guard < 1000) begin
      if (gaps && $urandom_range(0, 1) == 0) begin
        seg_count_valid = 1'b0;
      end else begin
        seg_count_valid = 1'b1;
        seg_count       = CNT_W'(vec[i]);
      end
      ok = seg_count_valid && seg_ready;
      @(posedge clk); #1;
      guard++;
      if (ok) i++;
    end
    seg_count_valid = 1'b0;
    if (i < nsend) check("segment_timeout", i, nsend);
  endtask

  task automatic start_pulse();
    start_query = 1'b1;
    @(posedge clk); #1;
    start_query = 1'b0;
  endtask

  task automatic run_query(input int vec[NS*NC], input int s0, input int s1, input int s2,
                           input int bcls, input int bsim, input bit gaps, input int hold,
                           input bit chk_lat);
    int lat;
    res_t r;
    exp_cs_q.push_back(s0);
    exp_cs_q.push_back(s1);
    exp_cs_q.push_back(s2);
    r.cls = bcls;
    r.sim = bsim;
    exp_res_q.push_back(r);
    start_pulse();
    check("busy_after_start", {31'd0, busy}, 1);
    check("err_cleared_by_start", {31'd0, err_overflow}, 0);
    lat = 1;
    fork
      drive_segs(vec, NS * NC, gaps);
      begin
        while (!result_valid && lat < 2000) begin
          @(posedge clk); #1;
          lat++;
        end
      end
    join
    if (!result_valid) check("result_timeout", 0, 1);
    if (chk_lat) check("start_to_result_latency", lat, NC * (NS + 1) + 1);
    for (int k = 0; k < hold; k++) begin
      if (k == 1) start_query = 1'b1;
      if (k == 2) start_query = 1'b0;
      check("hold_result_valid", {31'd0, result_valid}, 1);
      check("hold_best_class", {{(32-CLASS_W){1'b0}}, best_class}, bcls);
      check("hold_best_sim", {{(32-SIM_W){1'b0}}, best_sim}, bsim);
      @(posedge clk); #1;
    end
    start_query  = 1'b0;
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    check("result_valid_dropped", {31'd0, result_valid}, 0);
    check("idle_not_busy", {31'd0, busy}, 0);
    check("idle_best_class_kept", {{(32-CLASS_W){1'b0}}, best_class}, bcls);
    check("idle_best_sim_kept", {{(32-SIM_W){1'b0}}, best_sim}, bsim);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_seg_ready"}, {31'd0, seg_ready}, 0);
    check({tag, "_result_valid"}, {31'd0, result_valid}, 0);
    check({tag, "_class_sim_valid"}, {31'd0, class_sim_valid}, 0);
    check({tag, "_class_sim"}, {{(32-SIM_W){1'b0}}, class_sim}, 0);
    check({tag, "_best_class"}, {{(32-CLASS_W){1'b0}}, best_class}, 0);
    check({tag, "_best_sim"}, {{(32-SIM_W){1'b0}}, best_sim}, 0);
    check({tag, "_err_overflow"}, {31'd0, err_overflow}, 0);
  endtask

  int v_basic[NS*NC] = '{1, 2, 3, 4,   8, 8, 8, 8,     0, 0, 0, 1};
  int v_tie[NS*NC]   = '{5, 5, 5, 5,   2, 6, 10, 2,    1, 1, 1, 2};
  int v_full[NS*NC]  = '{32, 32, 0, 0, 32, 0, 32, 32,  32, 32, 32, 32};
  int v_ovf[NS*NC]   = '{40, 1, 1, 1,  2, 2, 2, 2,     3, 3, 3, 3};

  initial begin
    #2;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    arst_n_in = 1'b1;
    @(posedge clk); #1;
    check_all_zero("after_reset_release");

    // Sums 10/32/1 -> class 1 wins, minimum latency.
    run_query(v_basic, 10, 32, 1, 1, 32, 1'b0, 0, 1'b1);
    // Sums 20/20/5 -> tie keeps class 0.
    run_query(v_tie, 20, 20, 5, 0, 20, 1'b0, 0, 1'b0);
    // Random valid gaps, sums 64/96/128 -> class 2.
    run_query(v_full, 64, 96, 128, 2, 128, 1'b1, 0, 1'b0);
    // 40 clamps to 32: sums 35/8/12 -> class 0, sticky overflow flag.
    run_query(v_ovf, 35, 8, 12, 0, 35, 1'b0, 0, 1'b0);
    check("err_overflow_sticky", {31'd0, err_overflow}, 1);
    // Result held 5 cycles with a start pulse in DONE; start clears the error flag.
    run_query(v_basic, 10, 32, 1, 1, 32, 1'b0, 5, 1'b0);

    // Reset while class 1 is half accumulated: only class 0's sum is ever shown.
    exp_cs_q.push_back(20);
    start_pulse();
    drive_segs(v_tie, NS + 2, 1'b0);
    arst_n_in = 1'b0;
    #1;
    check_all_zero("mid_query_reset");
    check("mid_reset_class0_seen", exp_cs_q.size(), 0);
    exp_cs_q.delete();
    exp_res_q.delete();
    #2;
    arst_n_in = 1'b1;
    @(posedge clk); #1;
    run_query(v_basic, 10, 32, 1, 1, 32, 1'b0, 0, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    check("class_sim_queue_drained", exp_cs_q.size(), 0);
    check("result_queue_drained", exp_res_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
